// File: rtl/uart_tx_arbiter_if.sv
// Requester bus and UART TX pins shared by the tx arbiter.
// master: producers + UART side; slave: the arbiter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               transmit;
  logic [7:0]         TxData;
  logic               busy;
  logic [IW-1:0]      grant_id;
  logic               active;
  logic               timeout_err;

  modport master (
    output req_valid, req_data, busy,
    input  req_ready, transmit, TxData,
    input  grant_id, active, timeout_err
  );

  modport slave (
    input  req_valid, req_data, busy,
    output req_ready, transmit, TxData,
    output grant_id, active, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX among N_REQ producers.
// Ports: clk, reset (sync, high), bus (requesters + UART pins).
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int LAUNCH_TIMEOUT = 64
) (
  input logic             clk,
  input logic             reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(LAUNCH_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE
  } state_t;

  state_t state, state_nx;

  logic          busy_m, busy_s;
  logic [IW-1:0] last, win, cand, grant_q;
  logic [CW-1:0] cnt;
  logic [7:0]    tx_q, win_byte;
  logic          found, accept, cnt_end;

  // busy comes from the baud-clocked transmitter
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_m <= 1'b0;
      busy_s <= 1'b0;
    end else begin
      busy_m <= bus.busy;
      busy_s <= busy_m;
    end
  end

  // first valid requester after last, wrapping
  always_comb begin
    win      = '0;
    cand     = '0;
    found    = 1'b0;
    win_byte = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IW'((int'(last) + i) % N_REQ);
      if (!found && bus.req_valid[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (IW'(j) == win) begin
        win_byte = bus.req_data[8*j +: 8];
      end
    end
  end

  // no strobe may escape while reset is held
  assign accept  = (state == IDLE) && !busy_s
                && found && !reset;
  assign cnt_end = cnt == CW'(LAUNCH_TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    bus.req_ready   = '0;
    bus.transmit    = 1'b0;
    bus.timeout_err = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          bus.req_ready[win] = 1'b1;
          state_nx           = LAUNCH;
        end
      end
      LAUNCH: begin
        bus.transmit = 1'b1;
        if (busy_s) begin
          state_nx = WAIT_DONE;
        end else if (cnt_end) begin
          bus.timeout_err = 1'b1;
          state_nx        = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!busy_s) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last    <= IW'(N_REQ - 1);
      grant_q <= '0;
      tx_q    <= '0;
      cnt     <= '0;
    end else if (accept) begin
      last    <= win;
      grant_q <= win;
      tx_q    <= win_byte;
      cnt     <= '0;
    end else if (state == LAUNCH
                 && !busy_s && !cnt_end) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bus.TxData   = tx_q;
  assign bus.grant_id = grant_q;
  assign bus.active   = state != IDLE;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural UART TX stub.
// Table vectors, corner sequences and a random round-robin model.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stub_en = 1'b1;
  logic stub_busy = 1'b0;
  logic force_busy = 1'b0;
  logic [7:0] cap_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int m_last = 3;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(4)) bus ();

  assign bus.busy = stub_busy | force_busy;

  uart_tx_arbiter #(
    .N_REQ(4),
    .LAUNCH_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    int          g;
    logic [7:0]  b;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // UART TX stand-in: busy rises a few clocks after
  // transmit, off the clk edges, then holds for a frame
  initial begin
    int n;
    forever begin
      @(negedge clk);
      if (bus.transmit && stub_en
          && !stub_busy && !reset) begin
        n = $urandom_range(0, 3);
        repeat (n) @(posedge clk);
        @(posedge clk);
        #3 stub_busy = 1'b1;
        cap_q.push_back(bus.TxData);
        n = $urandom_range(4, 12);
        for (int i = 0; i < n; i++) begin
          @(posedge clk);
          if (reset) break;
        end
        #3 stub_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not end");
    $fatal(1);
  end

  function automatic int rr_pick(input logic [3:0] v,
                                 input int lst);
    int best;
    int bd;
    int dd;
    best = -1;
    bd = 99;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        dd = (i - lst - 1 + 8) % 4;
        if (dd < bd) begin
          bd = dd;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic wait_ready(output int k);
    k = 0;
    #1;
    while (bus.req_ready == 4'b0 && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("ready_wait", 32'(k < 300), 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.active && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", 32'(k < 500), 1);
  endtask

  task automatic run_txn(input logic [3:0]  v,
                         input logic [31:0] d,
                         input int          eg,
                         input logic [7:0]  eb);
    int k;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_data  = d;
    wait_ready(k);
    chk("req_ready", 32'(bus.req_ready), 32'(1 << eg));
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    chk("transmit", 32'(bus.transmit), 1);
    chk("TxData", 32'(bus.TxData), 32'(eb));
    chk("grant_id", 32'(bus.grant_id), 32'(eg));
    chk("active", 32'(bus.active), 1);
    wait_idle();
    chk("cap_count", 32'(cap_q.size()), 1);
    if (cap_q.size() > 0) begin
      chk("cap_byte", 32'(cap_q.pop_front()), 32'(eb));
    end
    cap_q.delete();
    m_last = eg;
  endtask

  initial begin
    int k;
    int txc;
    int top;
    int tat;
    logic [3:0]  rv;
    logic [31:0] rd;
    int          rg;

    tbl[0] = '{4'b1111, 32'h23222120, 0, 8'h20};
    tbl[1] = '{4'b1111, 32'h33323130, 1, 8'h31};
    tbl[2] = '{4'b0001, 32'h43424140, 0, 8'h40};
    tbl[3] = '{4'b1010, 32'h53525150, 1, 8'h51};
    tbl[4] = '{4'b1001, 32'h63626160, 3, 8'h63};
    tbl[5] = '{4'b0110, 32'h73727170, 1, 8'h71};
    tbl[6] = '{4'b0100, 32'h83828180, 2, 8'h82};
    tbl[7] = '{4'b0101, 32'h93929190, 0, 8'h90};
    tbl[8] = '{4'b1000, 32'hA3A2A1A0, 3, 8'hA3};
    tbl[9] = '{4'b0011, 32'hB3B2B1B0, 0, 8'hB0};

    // reset held with every requester valid
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h13121110;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_transmit", 32'(bus.transmit), 0);
      chk("rst_TxData", 32'(bus.TxData), 0);
      chk("rst_grant", 32'(bus.grant_id), 0);
      chk("rst_active", 32'(bus.active), 0);
      chk("rst_timeout", 32'(bus.timeout_err), 0);
    end
    bus.req_valid = '0;
    reset = 1'b0;

    // fairness: 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++) begin
      run_txn(4'b1111, 32'h13121110, i % 4,
              8'(8'h10 + (i % 4)));
    end

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].v, tbl[i].d, tbl[i].g, tbl[i].b);
    end

    // timeout: transmitter never answers
    stub_en = 1'b0;
    @(negedge clk);
    bus.req_valid = 4'b0010;
    bus.req_data  = 32'h44332211;
    wait_ready(k);
    chk("to_ready", 32'(bus.req_ready), 32'b0010);
    @(posedge clk);
    #1 bus.req_valid = '0;
    txc = 0;
    top = 0;
    tat = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.transmit) txc++;
      if (bus.timeout_err) begin
        top++;
        tat = c;
      end
    end
    chk("to_tx_cycles", 32'(txc), 64);
    chk("to_pulses", 32'(top), 1);
    chk("to_pulse_cycle", 32'(tat), 63);
    chk("to_active", 32'(bus.active), 0);
    chk("to_no_frame", 32'(cap_q.size()), 0);
    stub_en = 1'b1;
    run_txn(4'b0100, 32'h88776655, 2, 8'h77);

    // busy held high while idle
    @(posedge clk);
    #3 force_busy = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.req_valid = 4'b0001;
    bus.req_data  = 32'h000000C3;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.req_ready != 4'b0) k++;
    end
    chk("busy_no_grant", 32'(k), 0);
    @(posedge clk);
    #3 force_busy = 1'b0;
    k = 0;
    @(negedge clk);
    #1;
    while (bus.req_ready == 4'b0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("busy_release_lag", 32'(k), 2);
    chk("busy_ready", 32'(bus.req_ready), 32'b0001);
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    wait_idle();
    chk("busy_cap_count", 32'(cap_q.size()), 1);
    if (cap_q.size() > 0) begin
      chk("busy_cap", 32'(cap_q.pop_front()), 32'hC3);
    end
    cap_q.delete();

    // reset while in WAIT_DONE
    @(negedge clk);
    bus.req_valid = 4'b0100;
    bus.req_data  = 32'h00990000;
    wait_ready(k);
    @(posedge clk);
    #1 bus.req_valid = '0;
    k = 0;
    @(negedge clk);
    while (!(bus.active && !bus.transmit) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("wd_reached", 32'(k < 100), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_active", 32'(bus.active), 0);
    chk("mr_transmit", 32'(bus.transmit), 0);
    chk("mr_TxData", 32'(bus.TxData), 0);
    chk("mr_grant", 32'(bus.grant_id), 0);
    reset = 1'b0;
    cap_q.delete();
    repeat (3) @(negedge clk);
    run_txn(4'b1111, 32'h5A4B3C2D, 0, 8'h2D);
    run_txn(4'b1000, 32'hE1000000, 3, 8'hE1);

    // random masks against the round-robin model
    for (int i = 0; i < 30; i++) begin
      rv = 4'($urandom_range(1, 15));
      rd = $urandom;
      rg = rr_pick(rv, m_last);
      run_txn(rv, rd, rg, rd[8*rg +: 8]);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
